// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: sample-in / batch-out handshake bundle.
// master drives the sample and Out_ready, slave returns In_ready and the batch result.
// Ports (signals):
//   In_valid, Sum[3:0], Overflow, Out_ready  : master -> slave
//   In_ready, Out_valid, Acc[ACC_W-1:0],
//   Ovf_cnt[CNT_W-1:0], Acc_wrap             : slave -> master
interface sum_accumulator_if #(
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
);
    logic             In_valid;
    logic [3:0]       Sum;
    logic             Overflow;
    logic             In_ready;
    logic             Out_valid;
    logic             Out_ready;
    logic [ACC_W-1:0] Acc;
    logic [CNT_W-1:0] Ovf_cnt;
    logic             Acc_wrap;

    modport master (
        output In_valid, Sum, Overflow, Out_ready,
        input  In_ready, Out_valid, Acc, Ovf_cnt, Acc_wrap
    );

    modport slave (
        input  In_valid, Sum, Overflow, Out_ready,
        output In_ready, Out_valid, Acc, Ovf_cnt, Acc_wrap
    );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums N_SAMPLES {Overflow,Sum} samples, counts overflowed
// samples, and holds the batch result until the consumer takes it.
// Ports: Clk, Reset_n (async active-low), Clr (sync batch clear),
//        bus (sum_accumulator_if.slave: sample in, batch result out).
// Build option: define ACC_SAT_EN to clamp Acc at all-ones instead of wrapping.
module sum_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8,
    parameter int CNT_W     = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Clr,
    sum_accumulator_if.slave bus
);
    localparam int SC_W = $clog2(N_SAMPLES + 1);
    localparam logic [SC_W-1:0] LAST = SC_W'(N_SAMPLES - 1);

    if (N_SAMPLES < 2 || N_SAMPLES > 255) begin : g_bad_n
        $error("sum_accumulator: N_SAMPLES out of range 2..255");
    end
    if (ACC_W < 6 || ACC_W > 16) begin : g_bad_w
        $error("sum_accumulator: ACC_W out of range 6..16");
    end

    typedef enum logic {
        S_ACC,
        S_HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] ovf_q;
    logic             wrap_q;
    logic [SC_W-1:0]  smp_q;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             drain;
    logic             last;
    logic [ACC_W:0]   sample;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] acc_nxt;

    // A sample presented together with Clr is dropped, not accumulated.
    assign accept = bus.In_valid && in_ready && !Clr;
    assign drain  = out_valid && bus.Out_ready;
    assign last   = (smp_q == LAST);

    assign sample = {{(ACC_W - 4){1'b0}}, bus.Overflow, bus.Sum};
    assign sum_w  = {1'b0, acc_q} + sample;

`ifdef ACC_SAT_EN
    // Once clamped, adding zero keeps all-ones and any other value
    // carries again, so the clamp is self-sustaining for the batch.
    assign acc_nxt = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
    assign acc_nxt = sum_w[ACC_W-1:0];
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (Clr) begin
            state_nxt = S_ACC;
        end else begin
            unique case (state)
                S_ACC: begin
                    if (accept && last) begin
                        state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (drain) begin
                        state_nxt = S_ACC;
                    end
                end
                default: state_nxt = S_ACC;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_ACC:   in_ready  = 1'b1;
            S_HOLD:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_q  <= '0;
            ovf_q  <= '0;
            wrap_q <= 1'b0;
            smp_q  <= '0;
        end else if (Clr || drain) begin
            acc_q  <= '0;
            ovf_q  <= '0;
            wrap_q <= 1'b0;
            smp_q  <= '0;
        end else if (accept) begin
            acc_q  <= acc_nxt;
            wrap_q <= wrap_q | sum_w[ACC_W];
            smp_q  <= smp_q + 1'b1;
            if (bus.Overflow && (ovf_q != {CNT_W{1'b1}})) begin
                ovf_q <= ovf_q + 1'b1;
            end
        end
    end

    assign bus.In_ready  = in_ready;
    assign bus.Out_valid = out_valid;
    assign bus.Acc       = acc_q;
    assign bus.Ovf_cnt   = ovf_q;
    assign bus.Acc_wrap  = wrap_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: drives an 8-bit and a 6-bit accumulator with identical
// stimulus and compares both against a batch-level model.
module tb_sum_accumulator;
    localparam int N = 4;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic Clr = 1'b0;

    int checks = 0;
    int passed = 0;
    int q[$];

    sum_accumulator_if #(.ACC_W(8), .CNT_W(4)) bus8 ();
    sum_accumulator_if #(.ACC_W(6), .CNT_W(4)) bus6 ();

    sum_accumulator #(.N_SAMPLES(N), .ACC_W(8), .CNT_W(4)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .Clr(Clr), .bus(bus8)
    );
    sum_accumulator #(.N_SAMPLES(N), .ACC_W(6), .CNT_W(4)) dut6 (
        .Clk(Clk), .Reset_n(Reset_n), .Clr(Clr), .bus(bus6)
    );

    always #5 Clk = ~Clk;

    function automatic int total();
        int t = 0;
        foreach (q[i]) t += q[i];
        return t;
    endfunction

    function automatic int exp_acc(int w);
        int m = (1 << w) - 1;
`ifdef ACC_SAT_EN
        return (total() > m) ? m : total();
`else
        return total() % (m + 1);
`endif
    endfunction

    function automatic int exp_wrap(int w);
        return (total() > (1 << w) - 1) ? 1 : 0;
    endfunction

    function automatic int exp_ovf();
        int c = 0;
        foreach (q[i]) if (q[i] >= 16) c++;
        return (c > 15) ? 15 : c;
    endfunction

    function automatic int held();
        return (q.size() == N) ? 1 : 0;
    endfunction

    // Apply inputs, advance the model for this edge, settle 1 time unit after it.
    task automatic step(input bit v, input int s, input bit o,
                        input bit r, input bit c);
        bus8.In_valid = v; bus6.In_valid = v;
        bus8.Sum = 4'(s);  bus6.Sum = 4'(s);
        bus8.Overflow = o; bus6.Overflow = o;
        bus8.Out_ready = r; bus6.Out_ready = r;
        Clr = c;
        if (c) q.delete();
        else if (held() != 0 && r) q.delete();
        else if (held() == 0 && v) q.push_back(int'({o, 4'(s)}));
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 7, 0, 0, 0);
        step(1, 9, 1, 0, 0);
        #3;
        Reset_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (bus8.Acc !== 8'd0) $display("FAIL rst_acc8: got %0d want 0", bus8.Acc);
        else passed++;
        checks++;
        if (bus8.Ovf_cnt !== 4'd0) $display("FAIL rst_ovf8: got %0d want 0", bus8.Ovf_cnt);
        else passed++;
        checks++;
        if (bus8.Out_valid !== 1'b0 || bus6.Out_valid !== 1'b0)
            $display("FAIL rst_ovalid: got %b/%b want 0", bus8.Out_valid, bus6.Out_valid);
        else passed++;
        checks++;
        if (bus8.Acc_wrap !== 1'b0 || bus6.Acc_wrap !== 1'b0 || bus6.Acc !== 6'd0)
            $display("FAIL rst_misc6: got acc6=%0d wrap=%b/%b want 0",
                     bus6.Acc, bus8.Acc_wrap, bus6.Acc_wrap);
        else passed++;
        #1;
        Reset_n = 1'b1;
        step(0, 0, 0, 0, 0);
        checks++;
        if (bus8.In_ready !== 1'b1 || bus6.In_ready !== 1'b1)
            $display("FAIL rst_iready: got %b/%b want 1", bus8.In_ready, bus6.In_ready);
        else passed++;
    endtask

    task automatic test_normal();
        for (int i = 0; i < N; i++) begin
            step(1, 3, 0, 0, 0);
            checks++;
            if (bus8.Out_valid !== ((i == N - 1) ? 1'b1 : 1'b0))
                $display("FAIL norm_ovalid[%0d]: got %b want %b", i, bus8.Out_valid, i == N - 1);
            else passed++;
        end
        checks++;
        if (bus8.Acc !== 8'd12 || int'(bus8.Acc) != exp_acc(8))
            $display("FAIL norm_acc8: got %0d want 12", bus8.Acc);
        else passed++;
        checks++;
        if (int'(bus6.Acc) != exp_acc(6))
            $display("FAIL norm_acc6: got %0d want %0d", bus6.Acc, exp_acc(6));
        else passed++;
        checks++;
        if (bus8.Ovf_cnt !== 4'd0 || bus8.In_ready !== 1'b0)
            $display("FAIL norm_ovf_ird: got ovf=%0d ird=%b want 0/0", bus8.Ovf_cnt, bus8.In_ready);
        else passed++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0);
            checks++;
            if (bus8.Acc !== 8'd12 || bus8.Out_valid !== 1'b1 || bus8.In_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: got acc=%0d ov=%b ir=%b want 12/1/0",
                         i, bus8.Acc, bus8.Out_valid, bus8.In_ready);
            else passed++;
        end
        step(1, 1, 0, 1, 0);
        checks++;
        if (bus8.Out_valid !== 1'b0 || bus8.Acc !== 8'd0 || bus8.In_ready !== 1'b1)
            $display("FAIL bp_drain: got ov=%b acc=%0d ir=%b want 0/0/1",
                     bus8.Out_valid, bus8.Acc, bus8.In_ready);
        else passed++;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < N; i++) step(1, 14, 1, 0, 0);
        checks++;
        if (bus8.Acc !== 8'd120 || bus8.Ovf_cnt !== 4'd4 || bus8.Acc_wrap !== 1'b0)
            $display("FAIL ovf_acc8: got acc=%0d cnt=%0d wrap=%b want 120/4/0",
                     bus8.Acc, bus8.Ovf_cnt, bus8.Acc_wrap);
        else passed++;
        checks++;
`ifdef ACC_SAT_EN
        if (bus6.Acc !== 6'd63 || bus6.Acc_wrap !== 1'b1)
            $display("FAIL sat_acc6: got acc=%0d wrap=%b want 63/1", bus6.Acc, bus6.Acc_wrap);
        else passed++;
`else
        if (bus6.Acc !== 6'd56 || bus6.Acc_wrap !== 1'b1)
            $display("FAIL wrap_acc6: got acc=%0d wrap=%b want 56/1", bus6.Acc, bus6.Acc_wrap);
        else passed++;
`endif
        checks++;
        if (bus6.Ovf_cnt !== 4'd4)
            $display("FAIL ovf_cnt6: got %0d want 4", bus6.Ovf_cnt);
        else passed++;
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_clr();
        step(1, 5, 0, 0, 0);
        step(1, 5, 0, 0, 0);
        step(1, 5, 0, 0, 1);
        checks++;
        if (bus8.Acc !== 8'd0 || bus8.In_ready !== 1'b1 || bus8.Out_valid !== 1'b0)
            $display("FAIL clr_zero: got acc=%0d ir=%b ov=%b want 0/1/0",
                     bus8.Acc, bus8.In_ready, bus8.Out_valid);
        else passed++;
        for (int i = 0; i < N; i++) begin
            step(1, 5, 0, 0, 0);
            checks++;
            if (bus8.Out_valid !== ((i == N - 1) ? 1'b1 : 1'b0))
                $display("FAIL clr_batch[%0d]: got ov=%b want %b", i, bus8.Out_valid, i == N - 1);
            else passed++;
        end
        checks++;
        if (bus8.Acc !== 8'd20)
            $display("FAIL clr_acc8: got %0d want 20", bus8.Acc);
        else passed++;
        step(1, 5, 0, 0, 1);
        checks++;
        if (bus8.Out_valid !== 1'b0 || bus8.Acc !== 8'd0)
            $display("FAIL clr_hold: got ov=%b acc=%0d want 0/0", bus8.Out_valid, bus8.Acc);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 40) == 0));
            checks++;
            if (bus8.Out_valid !== 1'(held()) || bus8.In_ready !== 1'(held() == 0) ||
                bus6.Out_valid !== 1'(held()) || bus6.In_ready !== 1'(held() == 0))
                $display("FAIL rnd_hs[%0d]: got ov=%b ir=%b want ov=%0d", i,
                         bus8.Out_valid, bus8.In_ready, held());
            else passed++;
            checks++;
            if (int'(bus8.Acc) != exp_acc(8) || int'(bus8.Acc_wrap) != exp_wrap(8))
                $display("FAIL rnd_acc8[%0d]: got %0d/%b want %0d/%0d", i,
                         bus8.Acc, bus8.Acc_wrap, exp_acc(8), exp_wrap(8));
            else passed++;
            checks++;
            if (int'(bus6.Acc) != exp_acc(6) || int'(bus6.Acc_wrap) != exp_wrap(6))
                $display("FAIL rnd_acc6[%0d]: got %0d/%b want %0d/%0d", i,
                         bus6.Acc, bus6.Acc_wrap, exp_acc(6), exp_wrap(6));
            else passed++;
            checks++;
            if (int'(bus8.Ovf_cnt) != exp_ovf() || int'(bus6.Ovf_cnt) != exp_ovf())
                $display("FAIL rnd_ovf[%0d]: got %0d/%0d want %0d", i,
                         bus8.Ovf_cnt, bus6.Ovf_cnt, exp_ovf());
            else passed++;
        end
    endtask

    initial begin
        bus8.In_valid = 0; bus6.In_valid = 0;
        bus8.Sum = 0; bus6.Sum = 0;
        bus8.Overflow = 0; bus6.Overflow = 0;
        bus8.Out_ready = 0; bus6.Out_ready = 0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        step(0, 0, 0, 0, 0);
        test_reset();
        test_normal();
        test_backpressure();
        test_overflow();
        test_clr();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the registered 4-bit adder stage.
- Takes each {Overflow, Sum} result as a 5-bit unsigned sample under a valid/ready handshake.
- Accumulates N_SAMPLES samples into a wide running total and counts the overflowed samples.
- Presents the batch result under a valid/ready output handshake to the display/logging logic.

Parameters:
N_SAMPLES, 4, samples per batch; legal range 2..255.
ACC_W, 8, accumulator width; legal range 6..16.
CNT_W, 4, overflow-counter width; must hold N_SAMPLES or saturate.

Ports:
Clk  input  1  single clock; all state updates on posedge.
Reset_n  input  1  asynchronous active-low reset.
Clr  input  1  synchronous batch clear.
In_valid  input  1  Sum/Overflow sample present.
Sum  input  4  adder sum.
Overflow  input  1  adder carry-out.
In_ready  output  1  block accepts a sample this cycle.
Out_valid  output  1  batch result held.
Out_ready  input  1  consumer takes the result.
Acc  output  ACC_W  running or final total.
Ovf_cnt  output  CNT_W  samples with Overflow=1 in the current batch.
Acc_wrap  output  1  sticky flag: the accumulator exceeded 2^ACC_W-1 this batch.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (Clk, Reset_n). Reset_n low immediately forces:
  - state ACC, Acc=0, Ovf_cnt=0, Acc_wrap=0;
  - sample counter=0, Out_valid=0;
  - In_ready=1 once released.
- Sample value: {Overflow, Sum}, zero-extended to ACC_W+1 bits; range 0..30.
- Accept: In_valid && In_ready at a rising edge.
- State ACC:
  - Outputs: In_ready=1, Out_valid=0.
  - On accept: Acc <= (Acc+sample) mod 2^ACC_W; Acc_wrap |= carry out of bit ACC_W-1.
  - On accept with Overflow=1: Ovf_cnt increments and saturates at 2^CNT_W-1.
  - On accept: sample counter increments.
  - When the accept is sample N_SAMPLES, go to HOLD at the same edge. Out_valid=1 in the next cycle, so latency is 1 cycle from the final accept.
- State HOLD:
  - Outputs: In_ready=0, Out_valid=1.
  - Acc, Ovf_cnt and Acc_wrap are frozen.
  - In_valid is ignored; the upstream source must hold its sample.
  - Out_valid && Out_ready: go to ACC; clear Acc, Ovf_cnt, Acc_wrap and the sample counter. In_ready=1 on the next cycle, so there is no same-cycle pass-through.
- In ACC, Acc and Ovf_cnt show running values. They are valid only when Out_valid=1.
- Clr:
  - Highest synchronous priority in either state.
  - Next cycle: ACC with all counters zero.
  - A sample accepted in the same cycle as Clr is discarded.
- Reset_n asserted mid-batch or in HOLD: the batch is lost and the block returns to the reset values above.
- Counter boundary: the sample counter is ceil(log2(N_SAMPLES+1)) bits wide and never wraps in normal operation.

Optional Feature:
ACC_SAT_EN
- Defined: an add whose result would exceed 2^ACC_W-1 clamps Acc to all-ones, and Acc_wrap is set. Later adds in the batch keep Acc at all-ones.
- Undefined: modulo wrap as described in Behaviour; Acc_wrap still flags the carry.
- Ovf_cnt behaviour is identical in both builds.

Test Plan:
- Reset: assert Reset_n=0 mid-cycle with Acc non-zero -> Acc=0, Ovf_cnt=0, Out_valid=0, Acc_wrap=0 immediately; In_ready=1 after release.
- Normal batch (N=4, ACC_W=8): four back-to-back accepts of Sum=3, Overflow=0 -> Out_valid=1 on the cycle after the 4th accept; Acc=12, Ovf_cnt=0, In_ready=0.
- Backpressure: Out_ready=0 for 5 cycles while In_valid=1, Sum=1 -> Acc stays 12, no accepts. Out_ready=1 for 1 cycle -> next cycle Out_valid=0, Acc=0, In_ready=1.
- Overflow counting (N=4, ACC_W=8): four samples Overflow=1, Sum=4'hE (value 30) -> Acc=120, Ovf_cnt=4, Acc_wrap=0.
- Wrap and saturate (N=4, ACC_W=6, same four samples):
  - Without ACC_SAT_EN: Acc=56, Acc_wrap=1.
  - With ACC_SAT_EN: Acc=63, Acc_wrap=1.
- Clr: pulse Clr after 2 of 4 samples (Sum=5), with In_valid=1 in the Clr cycle -> next cycle Acc=0, counter=0. A full new batch is required before Out_valid rises.
